// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
// Counter encodings, initial counter value and the table entry layout.
package bp_pkg;

    localparam logic [1:0] CTR_SNT  = 2'b00;
    localparam logic [1:0] CTR_WNT  = 2'b01;
    localparam logic [1:0] CTR_WT   = 2'b10;
    localparam logic [1:0] CTR_ST   = 2'b11;
    localparam logic [1:0] CTR_INIT = CTR_WT;

    // tag holds pc[31:2]; the index bits in it always match, so
    // comparing the full word address equals comparing pc[31:IDX_W+2]
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [1:0]  ctr;
        logic [31:0] target;
    } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter next-state logic.
// Moves toward strong-taken on taken, strong-not-taken otherwise.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // saturate at both ends, never wrap
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST)
                ctr_next = ctr + 2'd1;
        end else if (ctr != CTR_SNT) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with target store and mispredict detect.
// Optional BP_STATS_EN adds branch and mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pred_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        res_valid_i,
    input  logic        res_is_branch_i,
    input  logic [31:0] res_pc_i,
    input  logic        res_taken_i,
    input  logic [31:0] res_target_i,
    input  logic        res_pred_taken_i,
    input  logic [31:0] res_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispredicts_o
`endif
);

    bp_entry_t        bp_table [ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    bp_entry_t        pred_e;
    bp_entry_t        res_e;
    logic             pred_hit;
    logic             res_hit;
    logic             upd;
    logic             mp_now;
    logic [1:0]       ctr_next;
    logic             unused_bits;

    assign pred_idx = pred_pc_i[IDX_W+1:2];
    assign res_idx  = res_pc_i[IDX_W+1:2];
    assign pred_e   = bp_table[pred_idx];
    assign res_e    = bp_table[res_idx];
    assign pred_hit = pred_e.valid && (pred_e.tag == pred_pc_i[31:2]);
    assign res_hit  = res_e.valid && (res_e.tag == res_pc_i[31:2]);
    assign upd      = res_valid_i && res_is_branch_i;

    assign unused_bits = ^{pred_pc_i[1:0], res_pc_i[1:0]};

    assign pred_taken_o  = pred_hit && pred_e.ctr[1];
    assign pred_target_o = pred_taken_o ? pred_e.target
                                        : pred_pc_i + 32'd4;

    assign mp_now = upd &&
        ((res_taken_i != res_pred_taken_i) ||
         (res_taken_i && res_pred_taken_i &&
          (res_target_i != res_pred_target_i)));

    sat_counter2 u_ctr (
        .ctr      (res_e.ctr),
        .taken    (res_taken_i),
        .ctr_next (ctr_next)
    );

    // train the table on resolved branches; allocate only on taken misses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                bp_table[i] <= '0;
        end else if (upd) begin
            if (res_hit) begin
                bp_table[res_idx].ctr <= ctr_next;
                if (res_taken_i)
                    bp_table[res_idx].target <= res_target_i;
            end else if (res_taken_i) begin
                bp_table[res_idx] <= '{valid:  1'b1,
                                       tag:    res_pc_i[31:2],
                                       ctr:    CTR_INIT,
                                       target: res_target_i};
            end
        end
    end

    // one-cycle mispredict pulse with the corrected fetch PC
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            mispredict_o  <= mp_now;
            redirect_pc_o <= res_taken_i ? res_target_i
                                         : res_pc_i + 32'd4;
        end
    end

`ifdef BP_STATS_EN
    // free-running event counters, wrap modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_o    <= '0;
            stat_mispredicts_o <= '0;
        end else begin
            if (upd)
                stat_branches_o <= stat_branches_o + 32'd1;
            if (mp_now)
                stat_mispredicts_o <= stat_mispredicts_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage, paired with the execute-stage branch comparator. It predicts taken/not-taken and the target at fetch, then trains on the resolved outcome. The comparator's taken result for each branch arrives on the resolve port. The block flags mispredictions and supplies the redirect PC to the PC/flush logic.

## Interface
Parameters:
- ENTRIES, 64, number of direct-mapped entries; power of two, 4..1024
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- pred_pc_i  input  32  fetch PC to look up
- pred_taken_o  output  1  predicted taken; combinational from pred_pc_i
- pred_target_o  output  32  predicted target; pred_pc_i+4 when not predicted taken
- res_valid_i  input  1  resolve slot valid
- res_is_branch_i  input  1  resolving instruction is a conditional branch
- res_pc_i  input  32  PC of the resolving branch
- res_taken_i  input  1  actual outcome (comparator taken output)
- res_target_i  input  32  actual branch target
- res_pred_taken_i  input  1  prediction carried down the pipe
- res_pred_target_i  input  32  predicted target carried down the pipe
- mispredict_o  output  1  registered one-cycle pulse
- redirect_pc_o  output  32  correct next PC; valid while mispredict_o=1

## Operation
- Entry fields: valid, tag = pc[31:IDX_W+2], 2-bit counter, target[31:0]. Index = pc[IDX_W+1:2]. pc[1:0] is ignored.
- Lookup:
  - hit = valid && tag match.
  - pred_taken_o = hit && ctr[1].
  - pred_target_o = stored target if pred_taken_o, else pred_pc_i+4 (mod 2^32).
- Update: occurs when res_valid_i && res_is_branch_i; the table is written at the clock edge.
  - On a hit:
    - taken → ctr = min(ctr+1, 3) and target = res_target_i.
    - not taken → ctr = max(ctr-1, 0); target is unchanged.
  - On a miss:
    - taken → allocate: valid=1, new tag, ctr=2'b10, target = res_target_i.
    - not taken → no allocation.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Counters saturate at both ends and never wrap.
- Mispredict is evaluated under res_valid_i && res_is_branch_i. It is set when res_taken_i != res_pred_taken_i, or when res_taken_i && res_pred_taken_i && res_target_i != res_pred_target_i.
- redirect_pc_o = res_taken_i ? res_target_i : res_pc_i+4.
- Non-branch resolves (res_is_branch_i=0) and slots with res_valid_i=0 cause no update and no mispredict.

## Timing
- Lookup is 0-cycle combinational from registered table state.
- Update is visible to a lookup in the cycle after the resolve edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update entry. There is no bypass.
- mispredict_o and redirect_pc_o are registered. They are valid 1 cycle after the resolve input and last exactly one cycle per qualifying resolve. Back-to-back mispredicting resolves give back-to-back pulses.
- Reset values:
  - all valid bits=0, mispredict_o=0, redirect_pc_o=0.
  - Counters and targets are don't-care but reset to 0 for determinism.
- rst has priority over any update in the same cycle. An in-flight resolve during rst is dropped, and no mispredict is emitted after reset.
- Immediately after reset, every lookup predicts not-taken with target pred_pc_i+4.

## Configuration
- BP_STATS_EN defined: adds outputs stat_branches_o[31:0] and stat_mispredicts_o[31:0].
  - stat_branches_o increments on every qualifying resolve.
  - stat_mispredicts_o increments on every mispredict.
  - Both reset to 0 and wrap modulo 2^32.
- BP_STATS_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- bp_pkg holds:
  - counter encodings CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11
  - CTR_INIT=CTR_WT
  - the entry struct typedef bp_entry_t
- Sub-module sat_counter2 is pure next-state logic, inputs ctr and taken, output next ctr. It is used in the update path.

## Test plan
- Reset, then lookup pc=0x100 → pred_taken_o=0, pred_target_o=0x104.
- Resolve pc=0x100 taken to 0x80 with pred_taken=0, then lookup 0x100 next cycle:
  - resolve cycle+1: mispredict_o=1, redirect_pc_o=0x80
  - lookup: pred_taken_o=1, target 0x80
- Three more taken resolves at 0x100 (ctr saturates at 11), then two not-taken:
  - after the first not-taken: still predicted taken (ctr=10)
  - after the second not-taken: predicted not-taken (ctr=01)
- Aliasing with ENTRIES=64: allocate 0x100, then resolve taken 0x200 (same index, different tag) → lookup 0x100 misses (not taken), lookup 0x200 hits.
- Taken with correct direction but wrong target: pred_target=0x80, actual 0x90 → mispredict_o=1, redirect_pc_o=0x90.
- rst asserted in the same cycle as a mispredicting resolve → no mispredict pulse. With BP_STATS_EN, both stats read 0.
